// File: rtl/alu_op_driver_pkg.sv
// Shared definitions for the ALU request/response driver: command codes,
// FSM encoding and settle-window bounds.
package alu_op_driver_pkg;

    typedef enum logic [2:0] {
        CMD_ADD  = 3'd0,
        CMD_SUB  = 3'd1,
        CMD_XOR  = 3'd2,
        CMD_SLT  = 3'd3,
        CMD_AND  = 3'd4,
        CMD_NAND = 3'd5,
        CMD_NOR  = 3'd6,
        CMD_OR   = 3'd7
    } alu_cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RESP   = 2'd2
    } drv_state_e;

    localparam int SETTLE_MIN = 1;
    localparam int SETTLE_MAX = 255;
    localparam int TIMER_W    = 8;

    // Out-of-range settle windows are clamped so the timer always terminates.
    function automatic logic [TIMER_W-1:0] settle_load(input int cycles);
        int c;
        c = cycles;
        if (c < SETTLE_MIN) c = SETTLE_MIN;
        if (c > SETTLE_MAX) c = SETTLE_MAX;
        return TIMER_W'(c - 1);
    endfunction

endpackage

// File: rtl/alu_op_driver_settle_timer.sv
// Loadable down-counter for the ALU settle window; done marks the enabled
// cycle in which the count has reached zero.
module alu_settle_timer
    import alu_op_driver_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_val,
    input  logic               en,
    output logic               done
);

    logic [TIMER_W-1:0] cnt_q;
    logic [TIMER_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - TIMER_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = en && !load && (cnt_q == '0);

endmodule

// File: rtl/alu_op_driver.sv
// Request/response front end for the combinational ALU: holds operands for a
// settle window, then captures result and flags for a valid/ready consumer.
//
// state  | meaning
// IDLE   | ready for a request; ALU inputs keep the last operands
// SETTLE | operands held on the ALU while the settle timer runs down
// RESP   | result captured, waiting for the consumer handshake
module alu_op_driver
    import alu_op_driver_pkg::*;
#(
    parameter int SETTLE_CYCLES = 8,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_command,
    input  logic [31:0]      req_a,
    input  logic [31:0]      req_b,
    output logic [31:0]      alu_operandA,
    output logic [31:0]      alu_operandB,
    output logic [2:0]       alu_command,
    input  logic [31:0]      alu_result,
    input  logic             alu_carryout,
    input  logic             alu_zero,
    input  logic             alu_overflow,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [2:0]       rsp_command,
    output logic [31:0]      rsp_result,
    output logic             rsp_carryout,
    output logic             rsp_zero,
    output logic             rsp_overflow,
    output logic [CNT_W-1:0] ops_done
);

    localparam logic [TIMER_W-1:0] LOAD_VAL = settle_load(SETTLE_CYCLES);

    drv_state_e       state_q, state_d;
    logic [31:0]      alu_a_q, alu_a_d;
    logic [31:0]      alu_b_q, alu_b_d;
    logic [2:0]       alu_cmd_q, alu_cmd_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [2:0]       rsp_cmd_q, rsp_cmd_d;
    logic [31:0]      rsp_result_q, rsp_result_d;
    logic             rsp_c_q, rsp_c_d;
    logic             rsp_z_q, rsp_z_d;
    logic             rsp_v_q, rsp_v_d;
    logic [CNT_W-1:0] ops_done_q, ops_done_d;

    logic accept;
    logic rsp_hs;
    logic timer_load;
    logic timer_done;

    // Ready follows rsp_ready in RESP so the next request can ride the handshake.
    assign req_ready = (state_q == ST_IDLE) || ((state_q == ST_RESP) && rsp_ready);
    assign accept    = req_valid && req_ready;
    assign rsp_hs    = rsp_valid_q && rsp_ready;

    always_comb begin
        state_d      = state_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_cmd_d    = alu_cmd_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_cmd_d    = rsp_cmd_q;
        rsp_result_d = rsp_result_q;
        rsp_c_d      = rsp_c_q;
        rsp_z_d      = rsp_z_q;
        rsp_v_d      = rsp_v_q;
        ops_done_d   = ops_done_q;
        timer_load   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    alu_a_d    = req_a;
                    alu_b_d    = req_b;
                    alu_cmd_d  = req_command;
                    timer_load = 1'b1;
                    state_d    = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (timer_done) begin
                    rsp_valid_d  = 1'b1;
                    rsp_cmd_d    = alu_cmd_q;
                    rsp_result_d = alu_result;
                    rsp_c_d      = alu_carryout;
                    rsp_z_d      = alu_zero;
                    rsp_v_d      = alu_overflow;
                    state_d      = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_hs) begin
                    rsp_valid_d = 1'b0;
                    ops_done_d  = ops_done_q + CNT_W'(1);
                    if (accept) begin
                        alu_a_d    = req_a;
                        alu_b_d    = req_b;
                        alu_cmd_d  = req_command;
                        timer_load = 1'b1;
                        state_d    = ST_SETTLE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_cmd_q    <= CMD_ADD;
            rsp_valid_q  <= 1'b0;
            rsp_cmd_q    <= '0;
            rsp_result_q <= '0;
            rsp_c_q      <= 1'b0;
            rsp_z_q      <= 1'b0;
            rsp_v_q      <= 1'b0;
            ops_done_q   <= '0;
        end else begin
            state_q      <= state_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_cmd_q    <= alu_cmd_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_cmd_q    <= rsp_cmd_d;
            rsp_result_q <= rsp_result_d;
            rsp_c_q      <= rsp_c_d;
            rsp_z_q      <= rsp_z_d;
            rsp_v_q      <= rsp_v_d;
            ops_done_q   <= ops_done_d;
        end
    end

    alu_settle_timer u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (timer_load),
        .load_val (LOAD_VAL),
        .en       (state_q == ST_SETTLE),
        .done     (timer_done)
    );

    assign alu_operandA = alu_a_q;
    assign alu_operandB = alu_b_q;
    assign alu_command  = alu_cmd_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_command  = rsp_cmd_q;
    assign rsp_result   = rsp_result_q;
    assign rsp_carryout = rsp_c_q;
    assign rsp_zero     = rsp_z_q;
    assign rsp_overflow = rsp_v_q;
    assign ops_done     = ops_done_q;

endmodule

// File: tb/tb_alu_op_driver.sv
// Bench for alu_op_driver: a behavioural ALU stands in for the real one, and
// expected responses come from operation-level rules and a response queue.
`timescale 1ns/1ps
module tb_alu_op_driver;
    import alu_op_driver_pkg::*;

    localparam int S_MAIN = 8;
    localparam int S_FAST = 1;
    localparam int W_FAST = 4;

    typedef struct packed {
        logic [31:0] res;
        logic        c;
        logic        z;
        logic        v;
    } alu_out_t;

    typedef struct {
        alu_out_t   exp;
        logic [2:0] cmd;
        int         acc;
    } entry_t;

    logic clk;
    logic rst_n;

    logic        req_valid, req_ready, rsp_valid, rsp_ready;
    logic [2:0]  req_command, alu_cmd, rsp_command;
    logic [31:0] req_a, req_b, alu_a, alu_b, alu_res, rsp_result;
    logic        alu_c, alu_z, alu_v, rsp_c, rsp_z, rsp_v;
    logic [15:0] ops_done;

    logic        f_req_valid, f_req_ready, f_rsp_valid, f_rsp_ready;
    logic [2:0]  f_req_command, f_alu_cmd, f_rsp_command;
    logic [31:0] f_req_a, f_req_b, f_alu_a, f_alu_b, f_alu_res, f_rsp_result;
    logic        f_alu_c, f_alu_z, f_alu_v, f_rsp_c, f_rsp_z, f_rsp_v;
    logic [W_FAST-1:0] f_ops_done;

    int          n_total;
    int          n_pass;
    logic [15:0] exp_done;

    function automatic alu_out_t alu_model(input logic [2:0] cmd, input logic [31:0] a,
                                           input logic [31:0] b);
        alu_out_t    o;
        logic [32:0] s;
        o = '0;
        s = '0;
        case (cmd)
            3'd0: begin
                s     = {1'b0, a} + {1'b0, b};
                o.res = s[31:0];
                o.c   = s[32];
                o.v   = (a[31] == b[31]) && (o.res[31] != a[31]);
                o.z   = (o.res == 32'd0);
            end
            3'd1: begin
                s     = {1'b0, a} + {1'b0, ~b} + 33'd1;
                o.res = s[31:0];
                o.c   = s[32];
                o.v   = (a[31] != b[31]) && (o.res[31] != a[31]);
                o.z   = (o.res == 32'd0);
            end
            3'd2:    o.res = a ^ b;
            3'd3:    o.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd4:    o.res = a & b;
            3'd5:    o.res = ~(a & b);
            3'd6:    o.res = ~(a | b);
            default: o.res = a | b;
        endcase
        return o;
    endfunction

    function automatic logic [31:0] rand_word();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'h7FFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    assign {alu_res, alu_c, alu_z, alu_v}         = alu_model(alu_cmd, alu_a, alu_b);
    assign {f_alu_res, f_alu_c, f_alu_z, f_alu_v} = alu_model(f_alu_cmd, f_alu_a, f_alu_b);

    alu_op_driver #(.SETTLE_CYCLES(S_MAIN), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_command(req_command),
        .req_a(req_a), .req_b(req_b),
        .alu_operandA(alu_a), .alu_operandB(alu_b), .alu_command(alu_cmd),
        .alu_result(alu_res), .alu_carryout(alu_c), .alu_zero(alu_z), .alu_overflow(alu_v),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_command(rsp_command),
        .rsp_result(rsp_result), .rsp_carryout(rsp_c), .rsp_zero(rsp_z),
        .rsp_overflow(rsp_v), .ops_done(ops_done)
    );

    alu_op_driver #(.SETTLE_CYCLES(S_FAST), .CNT_W(W_FAST)) u_fast (
        .clk(clk), .rst_n(rst_n),
        .req_valid(f_req_valid), .req_ready(f_req_ready), .req_command(f_req_command),
        .req_a(f_req_a), .req_b(f_req_b),
        .alu_operandA(f_alu_a), .alu_operandB(f_alu_b), .alu_command(f_alu_cmd),
        .alu_result(f_alu_res), .alu_carryout(f_alu_c), .alu_zero(f_alu_z),
        .alu_overflow(f_alu_v),
        .rsp_valid(f_rsp_valid), .rsp_ready(f_rsp_ready), .rsp_command(f_rsp_command),
        .rsp_result(f_rsp_result), .rsp_carryout(f_rsp_c), .rsp_zero(f_rsp_z),
        .rsp_overflow(f_rsp_v), .ops_done(f_ops_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_total);
        $fatal(1);
    end

    // Offers one request to the main driver while it is idle; returns on the
    // falling edge one cycle after the accepting edge.
    task automatic main_issue(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        req_valid   = 1'b1;
        req_command = c;
        req_a       = a;
        req_b       = b;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic main_wait_rsp(output int lat);
        lat = 1;
        while (!rsp_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic main_handshake();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_total++;
        if ({req_ready, rsp_valid, f_req_ready, f_rsp_valid} !== 4'b1010)
            $display("FAIL reset_handshake: got %b expected 1010",
                     {req_ready, rsp_valid, f_req_ready, f_rsp_valid});
        else n_pass++;
        n_total++;
        if ({alu_a, alu_b, alu_cmd} !== 67'd0)
            $display("FAIL reset_alu: got %h/%h/%0d expected 0/0/0", alu_a, alu_b, alu_cmd);
        else n_pass++;
        n_total++;
        if ({rsp_command, rsp_result, rsp_c, rsp_z, rsp_v} !== 38'd0)
            $display("FAIL reset_rsp: got cmd %0d res %h flags %b expected zeros",
                     rsp_command, rsp_result, {rsp_c, rsp_z, rsp_v});
        else n_pass++;
        n_total++;
        if (ops_done !== 16'd0 || f_ops_done !== 4'd0)
            $display("FAIL reset_ops_done: got %0d/%0d expected 0/0", ops_done, f_ops_done);
        else n_pass++;
        rst_n = 1'b1;
        @(negedge clk);
        n_total++;
        if ({req_ready, rsp_valid} !== 2'b10)
            $display("FAIL reset_release: got %b expected 10", {req_ready, rsp_valid});
        else n_pass++;
    endtask

    task automatic test_directed();
        logic [2:0]  cmds [3];
        logic [31:0] as [3];
        logic [31:0] bs [3];
        logic [31:0] res [3];
        logic [2:0]  flg [3];
        int          lat;
        cmds = '{CMD_ADD, CMD_SUB, CMD_SLT};
        as   = '{32'h7FFF_FFFF, 32'd5, 32'd3};
        bs   = '{32'h0000_0001, 32'd5, 32'd5};
        res  = '{32'h8000_0000, 32'd0, 32'd1};
        flg  = '{3'b001, 3'b110, 3'b000};
        for (int i = 0; i < 3; i++) begin
            main_issue(cmds[i], as[i], bs[i]);
            main_wait_rsp(lat);
            n_total++;
            if (lat !== S_MAIN + 1)
                $display("FAIL directed_latency[%0d]: got %0d expected %0d", i, lat, S_MAIN + 1);
            else n_pass++;
            n_total++;
            if (rsp_result !== res[i])
                $display("FAIL directed_result[%0d]: got %h expected %h", i, rsp_result, res[i]);
            else n_pass++;
            n_total++;
            if ({rsp_c, rsp_z, rsp_v} !== flg[i])
                $display("FAIL directed_flags[%0d]: got czv=%b expected %b", i,
                         {rsp_c, rsp_z, rsp_v}, flg[i]);
            else n_pass++;
            n_total++;
            if (rsp_command !== cmds[i])
                $display("FAIL directed_cmd[%0d]: got %0d expected %0d", i, rsp_command, cmds[i]);
            else n_pass++;
            main_handshake();
            exp_done++;
            n_total++;
            if (ops_done !== exp_done || rsp_valid !== 1'b0)
                $display("FAIL directed_done[%0d]: got ops %0d valid %b expected ops %0d valid 0",
                         i, ops_done, rsp_valid, exp_done);
            else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        logic [31:0]  a, b;
        logic [2:0]   c;
        alu_out_t     e;
        logic [104:0] want;
        int           lat;
        a    = $urandom;
        b    = $urandom;
        c    = CMD_SUB;
        e    = alu_model(c, a, b);
        want = {c, e, c, a, b};
        main_issue(c, a, b);
        main_wait_rsp(lat);
        n_total++;
        if (lat !== S_MAIN + 1)
            $display("FAIL bp_latency: got %0d expected %0d", lat, S_MAIN + 1);
        else n_pass++;
        for (int i = 0; i < 10; i++) begin
            req_valid   = 1'b1;
            req_command = CMD_XOR;
            req_a       = ~a;
            req_b       = ~b;
            @(negedge clk);
            n_total++;
            if ({rsp_command, rsp_result, rsp_c, rsp_z, rsp_v, alu_cmd, alu_a, alu_b} !== want)
                $display("FAIL bp_hold[%0d]: got res %h alu %h/%h expected res %h alu %h/%h", i,
                         rsp_result, alu_a, alu_b, e.res, a, b);
            else n_pass++;
            n_total++;
            if ({rsp_valid, req_ready} !== 2'b10 || ops_done !== exp_done)
                $display("FAIL bp_stall[%0d]: got valid/ready %b ops %0d expected 10 ops %0d", i,
                         {rsp_valid, req_ready}, ops_done, exp_done);
            else n_pass++;
        end
        req_valid = 1'b0;
        main_handshake();
        exp_done++;
        n_total++;
        if (ops_done !== exp_done || rsp_valid !== 1'b0)
            $display("FAIL bp_release: got ops %0d valid %b expected ops %0d valid 0",
                     ops_done, rsp_valid, exp_done);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if (ops_done !== exp_done || req_ready !== 1'b1)
            $display("FAIL bp_after: got ops %0d ready %b expected ops %0d ready 1",
                     ops_done, req_ready, exp_done);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [2:0]  cmds [4];
        logic [31:0] exps [4];
        int          k, gap, waited;
        cmds   = '{CMD_XOR, CMD_AND, CMD_NAND, CMD_OR};
        exps   = '{32'h0FF0_0FF0, 32'hF000_F000, 32'h0FFF_0FFF, 32'hFFF0_FFF0};
        k      = 0;
        gap    = 0;
        waited = 0;
        @(negedge clk);
        rsp_ready   = 1'b1;
        req_valid   = 1'b1;
        req_command = cmds[0];
        req_a       = 32'hF0F0_F0F0;
        req_b       = 32'hFF00_FF00;
        while (k < 4 && waited < 100) begin
            @(negedge clk);
            gap++;
            waited++;
            if (rsp_valid) begin
                n_total++;
                if (rsp_result !== exps[k])
                    $display("FAIL b2b_result[%0d]: got %h expected %h", k, rsp_result, exps[k]);
                else n_pass++;
                n_total++;
                if (gap !== S_MAIN + 1)
                    $display("FAIL b2b_spacing[%0d]: got %0d expected %0d", k, gap, S_MAIN + 1);
                else n_pass++;
                n_total++;
                if (req_ready !== 1'b1)
                    $display("FAIL b2b_ready[%0d]: got %b expected 1", k, req_ready);
                else n_pass++;
                k++;
                gap = 0;
                if (k < 4) req_command = cmds[k];
                else req_valid = 1'b0;
            end
        end
        n_total++;
        if (k !== 4) $display("FAIL b2b_count: got %0d responses expected 4", k);
        else n_pass++;
        @(negedge clk);
        rsp_ready = 1'b0;
        exp_done  = exp_done + 16'd4;
        n_total++;
        if (ops_done !== exp_done || rsp_valid !== 1'b0)
            $display("FAIL b2b_done: got ops %0d valid %b expected ops %0d valid 0",
                     ops_done, rsp_valid, exp_done);
        else n_pass++;
    endtask

    task automatic test_reset_mid_settle();
        logic seen;
        seen = 1'b0;
        main_issue(CMD_OR, 32'h0000_1234, 32'h00AB_0000);
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_total++;
        if ({req_ready, rsp_valid} !== 2'b10 || ops_done !== 16'd0)
            $display("FAIL midrst_ctrl: got ready/valid %b ops %0d expected 10 ops 0",
                     {req_ready, rsp_valid}, ops_done);
        else n_pass++;
        n_total++;
        if ({alu_a, alu_b, alu_cmd, rsp_result, rsp_command, rsp_c, rsp_z, rsp_v} !== 105'd0)
            $display("FAIL midrst_data: got alu %h/%h/%0d rsp %h expected zeros",
                     alu_a, alu_b, alu_cmd, rsp_result);
        else n_pass++;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        exp_done = 16'd0;
        n_total++;
        if (seen !== 1'b0 || ops_done !== 16'd0 || req_ready !== 1'b1)
            $display("FAIL midrst_after: got rsp seen %b ops %0d ready %b expected 0 0 1",
                     seen, ops_done, req_ready);
        else n_pass++;
    endtask

    task automatic test_random();
        entry_t sb[$];
        logic   exp_valid, exp_ready, drain;
        for (int cyc = 0; cyc < 460; cyc++) begin
            @(negedge clk);
            exp_valid = (sb.size() > 0) && ((cyc - sb[0].acc) >= S_MAIN + 1);
            n_total++;
            if (rsp_valid !== exp_valid)
                $display("FAIL random_valid @%0d: got %b expected %b", cyc, rsp_valid, exp_valid);
            else n_pass++;
            n_total++;
            if (ops_done !== exp_done)
                $display("FAIL random_done @%0d: got %0d expected %0d", cyc, ops_done, exp_done);
            else n_pass++;
            if (exp_valid) begin
                n_total++;
                if ({rsp_command, rsp_result, rsp_c, rsp_z, rsp_v} !== {sb[0].cmd, sb[0].exp})
                    $display("FAIL random_payload @%0d: got cmd %0d res %h czv %b expected cmd %0d res %h czv %b",
                             cyc, rsp_command, rsp_result, {rsp_c, rsp_z, rsp_v}, sb[0].cmd,
                             sb[0].exp.res, {sb[0].exp.c, sb[0].exp.z, sb[0].exp.v});
                else n_pass++;
            end
            drain       = (cyc >= 400);
            rsp_ready   = drain ? 1'b1 : ($urandom_range(0, 3) != 0);
            req_valid   = !drain && ($urandom_range(0, 2) != 0);
            req_command = 3'($urandom_range(0, 7));
            req_a       = rand_word();
            req_b       = rand_word();
            #1;
            exp_ready = (sb.size() == 0) || (exp_valid && rsp_ready);
            n_total++;
            if (req_ready !== exp_ready)
                $display("FAIL random_ready @%0d: got %b expected %b", cyc, req_ready, exp_ready);
            else n_pass++;
            if (exp_valid && rsp_ready) begin
                void'(sb.pop_front());
                exp_done++;
            end
            if (req_valid && exp_ready)
                sb.push_back('{alu_model(req_command, req_a, req_b), req_command, cyc});
        end
        req_valid = 1'b0;
        rsp_ready = 1'b0;
    endtask

    task automatic test_fast_wrap();
        logic [W_FAST-1:0] fd;
        logic [2:0]        c;
        logic [31:0]       a, b;
        alu_out_t          e;
        int                lat;
        fd = '0;
        for (int i = 0; i < 17; i++) begin
            c = 3'($urandom_range(0, 7));
            a = rand_word();
            b = rand_word();
            e = alu_model(c, a, b);
            @(negedge clk);
            f_req_valid   = 1'b1;
            f_req_command = c;
            f_req_a       = a;
            f_req_b       = b;
            @(negedge clk);
            f_req_valid = 1'b0;
            lat = 1;
            while (!f_rsp_valid && lat < 10) begin
                @(negedge clk);
                lat++;
            end
            n_total++;
            if (lat !== S_FAST + 1)
                $display("FAIL fast_latency[%0d]: got %0d expected %0d", i, lat, S_FAST + 1);
            else n_pass++;
            n_total++;
            if ({f_rsp_command, f_rsp_result, f_rsp_c, f_rsp_z, f_rsp_v} !== {c, e})
                $display("FAIL fast_payload[%0d]: got res %h expected %h", i, f_rsp_result, e.res);
            else n_pass++;
            f_rsp_ready = 1'b1;
            @(negedge clk);
            f_rsp_ready = 1'b0;
            fd++;
            n_total++;
            if (f_ops_done !== fd)
                $display("FAIL fast_ops_done[%0d]: got %0d expected %0d", i, f_ops_done, fd);
            else n_pass++;
        end
    endtask

    initial begin
        n_total       = 0;
        n_pass        = 0;
        exp_done      = '0;
        rst_n         = 1'b0;
        req_valid     = 1'b0;
        req_command   = '0;
        req_a         = '0;
        req_b         = '0;
        rsp_ready     = 1'b0;
        f_req_valid   = 1'b0;
        f_req_command = '0;
        f_req_a       = '0;
        f_req_b       = '0;
        f_rsp_ready   = 1'b0;
        test_reset();
        test_directed();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_settle();
        test_random();
        test_fast_wrap();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/alu_op_driver.md
Name: alu_op_driver

Overview:
- Sequential initiator that sits in front of the combinational 32-bit ALU and presents it as a request/response unit.
- Accepts an operation request (command plus operands) on a valid/ready port, then drives the ALU inputs and holds them stable for a programmable settle window.
- At the end of the window it captures the result and flags, and returns them on a valid/ready response port.
- Gives clocked logic (register file, test sequencers) a safe interface to the ALU, which has long gate-level delays.

Parameters:
- SETTLE_CYCLES, 8, clock cycles the ALU inputs are held before capture (legal range 1..255).
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request offered.
- req_ready  out  1  driver can accept a request this cycle.
- req_command  in  3  ALU command (ADD=0, SUB=1, XOR=2, SLT=3, AND=4, NAND=5, NOR=6, OR=7).
- req_a  in  32  operand A.
- req_b  in  32  operand B.
- alu_operandA  out  32  to ALU operandA.
- alu_operandB  out  32  to ALU operandB.
- alu_command  out  3  to ALU command.
- alu_result  in  32  from ALU result.
- alu_carryout  in  1  from ALU carryout.
- alu_zero  in  1  from ALU zero.
- alu_overflow  in  1  from ALU overflow.
- rsp_valid  out  1  response held.
- rsp_ready  in  1  consumer accepts the response.
- rsp_command  out  3  echo of the executed command.
- rsp_result  out  32  captured result.
- rsp_carryout  out  1  captured carry flag.
- rsp_zero  out  1  captured zero flag.
- rsp_overflow  out  1  captured overflow flag.
- ops_done  out  CNT_W  count of completed response handshakes.

Behaviour:
- Reset (async assert, sync release): state=IDLE; all outputs 0 except req_ready=1. This includes alu_command=ADD, alu_operandA/B=0, rsp_*=0, ops_done=0 and the settle counter=0.
- FSM states: IDLE, SETTLE, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, register req_command/req_a/req_b into the alu_* outputs, load the counter with SETTLE_CYCLES-1, and go to SETTLE.
- SETTLE:
  - req_ready=0; alu_* outputs are held constant.
  - The counter decrements each cycle.
  - In the cycle the counter reads 0, capture alu_result and the three flags into rsp_*, set rsp_command=alu_command, and go to RESP.
  - Accept-to-rsp_valid latency is exactly SETTLE_CYCLES+1 cycles. SETTLE_CYCLES=1 means capture on the first SETTLE cycle.
- RESP:
  - rsp_valid=1. rsp_* and alu_* outputs are stable until the handshake.
  - On rsp_valid&&rsp_ready, ops_done increments and rsp_valid drops next cycle.
  - req_ready = rsp_ready in RESP, so a new request can be accepted in the same cycle as the response handshake.
  - If a request is accepted in the handshake cycle, go straight to SETTLE with the new operands (back-to-back). Otherwise go to IDLE.
  - Sustained throughput is one operation per SETTLE_CYCLES+1 cycles.
- Backpressure: rsp_ready low holds RESP indefinitely with all outputs unchanged. req_ready stays 0 during this time.
- Flags are passed through raw. The driver does not mask by command; the ALU already zeroes flags for non-arithmetic ops.
- All 8 command codes are legal; there is no error path.
- ops_done wraps from 2^CNT_W-1 to 0 with no saturation and no side effect.
- rsp_valid never asserts without a preceding accepted request.
- Reset asserted mid-SETTLE or mid-RESP: immediate return to reset values and the in-flight operation is discarded. ops_done does not count it.
- req_* inputs are ignored whenever req_ready=0.

Decomposition:
- Shared package holds:
  - the 3-bit ALU command constants (ADD..OR),
  - the FSM state encoding (IDLE=0, SETTLE=1, RESP=2),
  - the SETTLE_CYCLES legal bounds.
- One natural sub-module, alu_settle_timer: a loadable down-counter with a done pulse.
- The FSM, operand/response registers and ops_done counter stay in the top module.

Test Plan:
- ADD A=0x7FFFFFFF B=0x00000001, rsp_ready=1 -> rsp_valid at accept+9 cycles, rsp_result=0x80000000, overflow=1, carryout=0, zero=0, ops_done=1.
- SUB A=5 B=5 -> rsp_result=0, zero=1, carryout=1, overflow=0. SLT A=3 B=5 -> rsp_result=1, all flags 0.
- Backpressure: hold rsp_ready=0 for 10 cycles after rsp_valid -> rsp_* and alu_* unchanged and req_ready=0 throughout. Raising rsp_ready completes the handshake and ops_done increments once.
- Back-to-back: req_valid held high with 4 queued ops (XOR, AND, NAND, OR on 0xF0F0F0F0 and 0xFF00FF00) -> each accepted in its predecessor's handshake cycle. Results are 0x0FF00FF0, 0xF000F000, 0x0FFF0FFF, 0xFFF0FFF0, one per 9 cycles.
- Reset mid-SETTLE (rst_n low 3 cycles into SETTLE) -> all outputs at reset values immediately, no response emitted, ops_done=0, and req_ready=1 after release.
- Counter wrap with CNT_W=4: 17 operations -> ops_done reads 15 after the 15th and 0 after the 16th. SETTLE_CYCLES=1 -> latency 2 cycles.
